// File: rtl/pulse_cmd_pkg.sv
// Shared types and constants for the pulse command issuer slice.
package pulse_cmd_pkg;

  localparam int unsigned CODE_W = 3;

  localparam logic [CODE_W-1:0] CODE_NONE = 3'd0;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_WAIT_HI,
    PC_WAIT_LO
  } pc_state_t;

endpackage

// File: rtl/pulse_cmd_fifo.sv
// Show-ahead synchronous FIFO holding pending command codes.
// Pushes are ignored when full and pops are ignored when empty.
module pulse_cmd_fifo
  import pulse_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [CODE_W-1:0]        din,
  output logic [CODE_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pulse_cmd_issuer.sv
// Buffers 3-bit commands and issues each as a single-cycle pulse into a
// fast-to-slow pulse synchronizer, tracking its busy flag through rise and
// fall. Optional wait-state watchdog: define PULSE_CMD_ISSUER_TIMEOUT_EN.
module pulse_cmd_issuer
  import pulse_cmd_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [CODE_W-1:0]        req_code,
  output logic                     req_ready,
  input  logic                     busy,
  output logic [CODE_W-1:0]        sig_3bit,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     idle,
  output logic                     err_timeout
);

  pc_state_t             state_q, state_d;
  logic [CODE_W-1:0]     sig_q, sig_d;
  logic                  fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [CODE_W-1:0]     fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  wd_expire;
  logic                  wd_fire;

  assign fifo_push = req_valid && !fifo_full && (req_code != CODE_NONE);

  pulse_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (req_code),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign req_ready = !fifo_full;
  assign pending   = fifo_count;
  assign sig_3bit  = sig_q;
  assign idle      = (state_q == PC_IDLE) && (fifo_count == '0);

  // Issue/handshake FSM: pulse the head once, then follow busy high and low.
  always_comb begin
    state_d  = state_q;
    sig_d    = CODE_NONE;
    fifo_pop = 1'b0;
    wd_fire  = 1'b0;
    unique case (state_q)
      PC_IDLE: begin
        if (!fifo_empty && !busy) begin
          sig_d    = fifo_head;
          fifo_pop = 1'b1;
          state_d  = PC_WAIT_HI;
        end
      end
      PC_WAIT_HI: begin
        if (busy) begin
          state_d = PC_WAIT_LO;
        end else if (wd_expire) begin
          state_d = PC_IDLE;
          wd_fire = 1'b1;
        end
      end
      PC_WAIT_LO: begin
        if (!busy) begin
          state_d = PC_IDLE;
        end else if (wd_expire) begin
          state_d = PC_IDLE;
          wd_fire = 1'b1;
        end
      end
      default: state_d = PC_IDLE;
    endcase
  end

  // State and pulse output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PC_IDLE;
      sig_q   <= CODE_NONE;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
    end
  end

`ifdef PULSE_CMD_ISSUER_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Expiry fires on the edge at which the counter would reach TIMEOUT.
  assign wd_expire   = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign err_timeout = err_q;

  // Wait-state age counter; cleared on every state change so each wait
  // state gets its own full budget.
  always_comb begin
    cnt_d = cnt_q;
    err_d = wd_fire;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != PC_IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_wd;

  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
  assign unused_wd   = ^{TIMEOUT, wd_fire};
`endif

endmodule

// File: tb/tb_pulse_cmd_issuer.sv
// Self-checking bench for pulse_cmd_issuer: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_pulse_cmd_issuer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam int          PW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [2:0]    req_code;
  logic          req_ready;
  logic          busy;
  logic [2:0]    sig_3bit;
  logic [PW-1:0] pending;
  logic          idle;
  logic          err_timeout;

  always #5 clk = ~clk;

  pulse_cmd_issuer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_code    (req_code),
    .req_ready   (req_ready),
    .busy        (busy),
    .sig_3bit    (sig_3bit),
    .pending     (pending),
    .idle        (idle),
    .err_timeout (err_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting codes plus the handshake phase
  // (0 ready to issue, 1 awaiting busy rise, 2 awaiting busy fall).
  int mq[$];
  int m_phase = 0;
  int m_age   = 0;
  int m_sig   = 0;
  bit m_err   = 1'b0;
  bit started = 1'b0;

  always @(posedge clk) begin : model
    bit room;
    bit issue;
    started = 1'b1;
    if (rst) begin
      mq.delete();
      m_phase = 0;
      m_age   = 0;
      m_sig   = 0;
      m_err   = 1'b0;
    end else begin
      room  = (mq.size() < DEPTH);
      issue = 1'b0;
      m_sig = 0;
      m_err = 1'b0;
      if (m_phase == 0) begin
        if (mq.size() != 0 && !busy) issue = 1'b1;
      end else begin
        m_age++;
        if (m_phase == 1 && busy) begin
          m_phase = 2;
          m_age   = 0;
        end else if (m_phase == 2 && !busy) begin
          m_phase = 0;
        end
`ifdef PULSE_CMD_ISSUER_TIMEOUT_EN
        else if (m_age == TIMEOUT) begin
          m_phase = 0;
          m_err   = 1'b1;
        end
`endif
      end
      if (issue) begin
        m_sig   = mq.pop_front();
        m_phase = 1;
        m_age   = 0;
      end
      if (req_valid && room && req_code != 3'd0) mq.push_back(int'(req_code));
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  int plog[$];
  always @(negedge clk) begin
    if (started) begin
      cmp("sig_3bit",    32'(sig_3bit),    m_sig);
      cmp("pending",     32'(pending),     mq.size());
      cmp("req_ready",   32'(req_ready),   32'(mq.size() < DEPTH));
      cmp("idle",        32'(idle),        32'(m_phase == 0 && mq.size() == 0));
      cmp("err_timeout", 32'(err_timeout), 32'(m_err));
      if (sig_3bit != 3'd0) plog.push_back(int'(sig_3bit));
    end
  end

  // Synchronizer stand-in: busy rises two cycles after a pulse, stays 8.
  bit hold_busy = 1'b0;
  bit auto_busy = 1'b1;
  bit resp_busy = 1'b0;
  int resp_t    = 0;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (auto_busy) begin
        if (resp_t > 0) begin
          resp_t++;
          if (resp_t == 3) resp_busy = 1'b1;
          if (resp_t == 11) begin
            resp_busy = 1'b0;
            resp_t    = 0;
          end
        end else if (sig_3bit != 3'd0) begin
          resp_t = 1;
        end
      end
      busy = hold_busy | resp_busy;
    end
  endtask

  task automatic push(input logic [2:0] c);
    req_valid = 1'b1;
    req_code  = c;
    run(1);
    req_valid = 1'b0;
    req_code  = 3'd0;
  endtask

  task automatic push_wait(input logic [2:0] c);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_code  = c;
    while (!req_ready && n < 40) begin
      run(1);
      n++;
    end
    cmp("push_wait_ready", 32'(req_ready), 1);
    run(1);
    req_valid = 1'b0;
    req_code  = 3'd0;
  endtask

  task automatic chk_log(input string nm, input int e[$]);
    cmp({nm, "_count"}, plog.size(), e.size());
    for (int i = 0; i < e.size() && i < plog.size(); i++)
      cmp($sformatf("%s_%0d", nm, i), plog[i], e[i]);
  endtask

  initial begin : stim
    int exp_q[$];
    rst       = 1'b1;
    req_valid = 1'b1;
    req_code  = 3'd5;
    busy      = 1'b0;

    // Reset with a live request: nothing may be queued.
    run(3);
    cmp("rst_pending", 32'(pending),  0);
    cmp("rst_sig",     32'(sig_3bit), 0);
    cmp("rst_idle",    32'(idle),     1);
    cmp("rst_ready",   32'(req_ready), 1);
    rst       = 1'b0;
    req_valid = 1'b0;
    req_code  = 3'd0;
    run(2);

    // Single command: pulse on the edge after acceptance, one cycle wide.
    plog.delete();
    push(3'd6);
    cmp("single_pending", 32'(pending), 1);
    run(1);
    cmp("single_pulse", 32'(sig_3bit), 6);
    run(1);
    cmp("single_pulse_end", 32'(sig_3bit), 0);
    run(14);
    cmp("single_idle", 32'(idle), 1);

    // Fill while busy, then drain in order.
    plog.delete();
    hold_busy = 1'b1;
    run(1);
    push(3'd1);
    push(3'd2);
    push(3'd3);
    push(3'd4);
    cmp("fill_pending", 32'(pending),   4);
    cmp("fill_ready",   32'(req_ready), 0);
    req_valid = 1'b1;
    req_code  = 3'd5;
    run(3);
    cmp("full_hold_pending", 32'(pending), 4);
    hold_busy = 1'b0;
    push_wait(3'd5);
    run(90);
    exp_q = {1, 2, 3, 4, 5};
    chk_log("fill_order", exp_q);
    cmp("fill_idle", 32'(idle), 1);

    // Zero code completes the handshake but is never queued or pulsed.
    plog.delete();
    push(3'd3);
    push(3'd0);
    cmp("zero_pending", 32'(pending), 0);
    push(3'd7);
    run(40);
    exp_q = {3, 7};
    chk_log("zero_codes", exp_q);

    // Reset while waiting for busy to fall with two commands queued.
    plog.delete();
    push(3'd1);
    push(3'd2);
    push(3'd4);
    run(3);
    cmp("rstw_pending_before", 32'(pending), 2);
    rst = 1'b1;
    run(1);
    cmp("rstw_pending_after", 32'(pending), 0);
    rst = 1'b0;
    run(30);
    exp_q = {1};
    chk_log("rstw_pulses", exp_q);
    cmp("rstw_idle", 32'(idle), 1);

`ifdef PULSE_CMD_ISSUER_TIMEOUT_EN
    // Watchdog: busy never rises, so the wait is abandoned and the next
    // queued code goes out.
    begin
      int n;
      auto_busy = 1'b0;
      resp_t    = 0;
      resp_busy = 1'b0;
      run(2);
      push(3'd2);
      push(3'd3);
      n = 0;
      while (err_timeout !== 1'b1 && n < 40) begin
        run(1);
        n++;
      end
      cmp("wd_latency", n, 15);
      run(1);
      cmp("wd_next_issue", 32'(sig_3bit), 3);
      run(40);
      auto_busy = 1'b1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got running expected finished at %0t", $time);
    $fatal(1, "bench did not terminate");
  end

endmodule
